// File: rtl/branch_predict_unit_pkg.sv
`default_nettype none
//============================================================================
// Module   : branch_predict_unit_pkg
// Brief    : Shared opcode, branch-condition and 2-bit counter definitions.
// Revision : 1.0 - initial release
//============================================================================
package branch_predict_unit_pkg;

    localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
    localparam logic [4:0] OPCODE_JAL    = 5'b11011;
    localparam logic [4:0] OPCODE_JALR   = 5'b11001;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_state_e;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] satStep(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage : branch_predict_unit_pkg
`default_nettype wire

// File: rtl/branch_predict_unit_if.sv
`default_nettype none
//============================================================================
// Module   : branch_predict_unit_if
// Brief    : Fetch lookup, execute resolution and statistics bundle.
// Revision : 1.0 - initial release
//============================================================================
interface branch_predict_unit_if #(
    parameter int PC_W   = 32,
    parameter int STAT_W = 16
);
    logic              f_valid;
    logic [PC_W-1:0]   f_pc;
    logic              pred_valid;
    logic              pred_taken;
    logic              ex_valid;
    logic [PC_W-1:0]   ex_pc;
    logic [4:0]        opcode;
    logic [2:0]        funct3;
    logic              cf;
    logic              zf;
    logic              vf;
    logic              sf;
    logic              ex_pred_taken;
    logic              br_taken;
    logic              mispredict;
    logic [STAT_W-1:0] branch_cnt;
    logic [STAT_W-1:0] mispredict_cnt;

    modport master (
        output f_valid, f_pc, ex_valid, ex_pc, opcode, funct3,
               cf, zf, vf, sf, ex_pred_taken,
        input  pred_valid, pred_taken, br_taken, mispredict,
               branch_cnt, mispredict_cnt
    );

    modport slave (
        input  f_valid, f_pc, ex_valid, ex_pc, opcode, funct3,
               cf, zf, vf, sf, ex_pred_taken,
        output pred_valid, pred_taken, br_taken, mispredict,
               branch_cnt, mispredict_cnt
    );
endinterface : branch_predict_unit_if
`default_nettype wire

// File: rtl/branch_predict_unit_bht.sv
`default_nettype none
//============================================================================
// Module   : bht_table
// Brief    : 2-bit saturating counter array with write-bypassed lookup.
// Revision : 1.0 - initial release
//============================================================================
module bht_table
    import branch_predict_unit_pkg::*;
#(
    parameter int         IDX_BITS = 4,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_rdEn,
    input  wire logic [IDX_BITS-1:0] i_rdIdx,
    input  wire logic                i_wrEn,
    input  wire logic [IDX_BITS-1:0] i_wrIdx,
    input  wire logic                i_wrTaken,
    output logic                     o_rdTaken
);
    localparam int c_DEPTH = 1 << IDX_BITS;

    logic [1:0] r_cnt [c_DEPTH];
    logic       r_rdTaken;
    logic [1:0] w_wrNext;
    logic [1:0] w_rdCnt;

    // A lookup colliding with this cycle's update sees the new counter value.
    always_comb begin
        w_wrNext = satStep(r_cnt[i_wrIdx], i_wrTaken);
        w_rdCnt  = r_cnt[i_rdIdx];
        if (i_wrEn && (i_wrIdx == i_rdIdx)) w_rdCnt = w_wrNext;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) r_cnt[i] <= CNT_INIT;
            r_rdTaken <= 1'b0;
        end else begin
            if (i_wrEn) r_cnt[i_wrIdx] <= w_wrNext;
            r_rdTaken <= i_rdEn & w_rdCnt[1];
        end
    end

    assign o_rdTaken = r_rdTaken;

endmodule : bht_table
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
//============================================================================
// Module   : branch_predict_unit
// Brief    : Bimodal branch predictor with execute-stage resolution and stats.
// Revision : 1.0 - initial release
//============================================================================
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int         IDX_BITS = 4,
    parameter int         PC_W     = 32,
    parameter logic [1:0] CNT_INIT = 2'b01,
    parameter int         STAT_W   = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    branch_predict_unit_if.slave bus
);
    logic [PC_W-1:0]     w_fPc;
    logic [PC_W-1:0]     w_exPc;
    logic [IDX_BITS-1:0] w_fIdx;
    logic [IDX_BITS-1:0] w_exIdx;
    logic                w_isBranch;
    logic                w_isJump;
    logic                w_defined;
    logic                w_cond;
    logic                w_brValid;
    logic                w_brTaken;
    logic                w_mispredict;
    logic                w_predTaken;
    logic                w_unused;

    logic                r_predValid;
    logic [STAT_W-1:0]   r_branchCnt;
    logic [STAT_W-1:0]   r_mispredictCnt;

    assign w_fPc   = bus.f_pc;
    assign w_exPc  = bus.ex_pc;
    assign w_fIdx  = w_fPc[IDX_BITS+1:2];
    assign w_exIdx = w_exPc[IDX_BITS+1:2];

    // Upper PC bits and the halfword offset play no part in indexing.
    assign w_unused = ^{w_fPc[PC_W-1:IDX_BITS+2], w_fPc[1:0],
                        w_exPc[PC_W-1:IDX_BITS+2], w_exPc[1:0]};

    always_comb begin
        w_isBranch = (bus.opcode == OPCODE_BRANCH);
        w_isJump   = (bus.opcode == OPCODE_JAL) || (bus.opcode == OPCODE_JALR);
        w_cond     = 1'b0;
        w_defined  = 1'b1;
        case (bus.funct3)
            BR_BEQ:  w_cond = bus.zf;
            BR_BNE:  w_cond = ~bus.zf;
            BR_BLT:  w_cond = (bus.sf != bus.vf);
            BR_BGE:  w_cond = (bus.sf == bus.vf);
            BR_BLTU: w_cond = ~bus.cf;
            BR_BGEU: w_cond = bus.cf;
            default: w_defined = 1'b0;
        endcase
        w_brValid    = bus.ex_valid & w_isBranch & w_defined;
        w_brTaken    = bus.ex_valid & ((w_isBranch & w_cond) | w_isJump);
        w_mispredict = w_brValid & (w_cond ^ bus.ex_pred_taken);
    end

    bht_table #(
        .IDX_BITS (IDX_BITS),
        .CNT_INIT (CNT_INIT)
    ) u_bht (
        .clk       (clk),
        .rst       (rst),
        .i_rdEn    (bus.f_valid),
        .i_rdIdx   (w_fIdx),
        .i_wrEn    (w_brValid),
        .i_wrIdx   (w_exIdx),
        .i_wrTaken (w_cond),
        .o_rdTaken (w_predTaken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_predValid     <= 1'b0;
            r_branchCnt     <= '0;
            r_mispredictCnt <= '0;
        end else begin
            r_predValid <= bus.f_valid;
            if (w_brValid && (r_branchCnt != '1))
                r_branchCnt <= r_branchCnt + STAT_W'(1);
            if (w_mispredict && (r_mispredictCnt != '1))
                r_mispredictCnt <= r_mispredictCnt + STAT_W'(1);
        end
    end

    assign bus.pred_valid     = r_predValid;
    assign bus.pred_taken     = w_predTaken;
    assign bus.br_taken       = w_brTaken;
    assign bus.mispredict     = w_mispredict;
    assign bus.branch_cnt     = r_branchCnt;
    assign bus.mispredict_cnt = r_mispredictCnt;

endmodule : branch_predict_unit
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module   : tb_branch_predict_unit
// Brief    : Directed self-checking bench for branch_predict_unit.
// Revision : 1.0 - initial release
//============================================================================
module tb_branch_predict_unit;
    import branch_predict_unit_pkg::*;

    localparam int c_PC_W   = 32;
    localparam int c_STAT_W = 16;

    logic clk;
    logic rst;
    int   nChecks;
    int   nErrors;

    branch_predict_unit_if #(.PC_W(c_PC_W), .STAT_W(c_STAT_W)) bus ();

    branch_predict_unit #(
        .IDX_BITS (4),
        .PC_W     (c_PC_W),
        .CNT_INIT (2'b01),
        .STAT_W   (c_STAT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drvEx(input logic v, input logic [4:0] op, input logic [2:0] f3,
                         input logic [31:0] pc, input logic c, input logic z,
                         input logic ov, input logic s, input logic pt);
        bus.ex_valid      = v;
        bus.opcode        = op;
        bus.funct3        = f3;
        bus.ex_pc         = pc;
        bus.cf            = c;
        bus.zf            = z;
        bus.vf            = ov;
        bus.sf            = s;
        bus.ex_pred_taken = pt;
    endtask

    task automatic lookup(input logic v, input logic [31:0] pc);
        bus.f_valid = v;
        bus.f_pc    = pc;
    endtask

    initial begin
        nChecks = 0;
        nErrors = 0;
        rst     = 1'b1;
        lookup(1'b0, 32'h0);
        drvEx(1'b0, 5'b00000, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_pred_valid", 32'(bus.pred_valid), 32'd0);
        chk("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
        chk("rst_branch_cnt", 32'(bus.branch_cnt), 32'd0);
        chk("rst_mis_cnt", 32'(bus.mispredict_cnt), 32'd0);
        rst = 1'b0;

        // Fresh entry is weakly not-taken.
        lookup(1'b1, 32'h40);
        step();
        chk("lk40_pred_valid", 32'(bus.pred_valid), 32'd1);
        chk("lk40_pred_taken", 32'(bus.pred_taken), 32'd0);

        // Four taken BEQs at idx 0 with bypassed lookup: 01->10->11->11->11.
        for (int i = 0; i < 4; i++) begin
            drvEx(1'b1, OPCODE_BRANCH, BR_BEQ, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            #1;
            chk("beq_br_taken", 32'(bus.br_taken), 32'd1);
            chk("beq_mispredict", 32'(bus.mispredict), 32'd1);
            step();
            chk("beq_pred_taken", 32'(bus.pred_taken), 32'd1);
        end
        chk("beq_branch_cnt", 32'(bus.branch_cnt), 32'd4);
        chk("beq_mis_cnt", 32'(bus.mispredict_cnt), 32'd4);

        // Two not-taken BEQs walk 11->10 (still taken) then 10->01.
        drvEx(1'b1, OPCODE_BRANCH, BR_BEQ, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step();
        chk("nt1_pred_taken", 32'(bus.pred_taken), 32'd1);
        step();
        chk("nt2_pred_taken", 32'(bus.pred_taken), 32'd0);
        chk("nt_branch_cnt", 32'(bus.branch_cnt), 32'd6);
        chk("nt_mis_cnt", 32'(bus.mispredict_cnt), 32'd6);

        drvEx(1'b0, 5'b00000, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        lookup(1'b0, 32'h40);
        step();
        chk("nolk_pred_valid", 32'(bus.pred_valid), 32'd0);
        chk("nolk_pred_taken", 32'(bus.pred_taken), 32'd0);

        // Gated and non-branch cases have no effect.
        drvEx(1'b0, OPCODE_BRANCH, BR_BEQ, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("exv0_br_taken", 32'(bus.br_taken), 32'd0);
        chk("exv0_mispredict", 32'(bus.mispredict), 32'd0);
        drvEx(1'b1, 5'b01100, BR_BEQ, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("alu_br_taken", 32'(bus.br_taken), 32'd0);
        chk("alu_mispredict", 32'(bus.mispredict), 32'd0);
        step();
        chk("alu_branch_cnt", 32'(bus.branch_cnt), 32'd6);

        // BLT taken at idx 1 (01->10), correctly predicted.
        drvEx(1'b1, OPCODE_BRANCH, BR_BLT, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        chk("blt_br_taken", 32'(bus.br_taken), 32'd1);
        chk("blt_mispredict", 32'(bus.mispredict), 32'd0);
        step();
        chk("blt_branch_cnt", 32'(bus.branch_cnt), 32'd7);
        chk("blt_mis_cnt", 32'(bus.mispredict_cnt), 32'd6);

        // Reserved funct3 must leave idx 1 at 10 and the stats untouched.
        drvEx(1'b1, OPCODE_BRANCH, 3'b010, 32'h44, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        chk("rsv_br_taken", 32'(bus.br_taken), 32'd0);
        chk("rsv_mispredict", 32'(bus.mispredict), 32'd0);
        step();
        chk("rsv_branch_cnt", 32'(bus.branch_cnt), 32'd7);
        chk("rsv_mis_cnt", 32'(bus.mispredict_cnt), 32'd6);
        drvEx(1'b0, 5'b00000, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        lookup(1'b1, 32'h44);
        step();
        chk("rsv_bht_kept", 32'(bus.pred_taken), 32'd1);

        // BGEU with cf=0 is not taken: idx 1 10->01.
        drvEx(1'b1, OPCODE_BRANCH, BR_BGEU, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("bgeu_br_taken", 32'(bus.br_taken), 32'd0);
        chk("bgeu_mispredict", 32'(bus.mispredict), 32'd0);
        step();
        chk("bgeu_pred_taken", 32'(bus.pred_taken), 32'd0);
        chk("bgeu_branch_cnt", 32'(bus.branch_cnt), 32'd8);

        // Jumps resolve taken but never train or count; idx 0 stays 01.
        lookup(1'b1, 32'h40);
        drvEx(1'b1, OPCODE_JAL, 3'b000, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("jal_br_taken", 32'(bus.br_taken), 32'd1);
        chk("jal_mispredict", 32'(bus.mispredict), 32'd0);
        step();
        drvEx(1'b1, OPCODE_JALR, 3'b000, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("jalr_br_taken", 32'(bus.br_taken), 32'd1);
        chk("jalr_mispredict", 32'(bus.mispredict), 32'd0);
        step();
        chk("jmp_pred_taken", 32'(bus.pred_taken), 32'd0);
        chk("jmp_branch_cnt", 32'(bus.branch_cnt), 32'd8);
        chk("jmp_mis_cnt", 32'(bus.mispredict_cnt), 32'd6);

        // idx 3: one taken update to WT, then WT->ST with same-cycle lookup.
        lookup(1'b0, 32'h0);
        drvEx(1'b1, OPCODE_BRANCH, BR_BNE, 32'h0C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        lookup(1'b1, 32'h0C);
        drvEx(1'b1, OPCODE_BRANCH, BR_BGE, 32'h0C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step();
        chk("byp_pred_taken", 32'(bus.pred_taken), 32'd1);
        chk("byp_branch_cnt", 32'(bus.branch_cnt), 32'd10);
        chk("byp_mis_cnt", 32'(bus.mispredict_cnt), 32'd7);

        // Reset beats a simultaneous taken branch at idx 3.
        lookup(1'b1, 32'h0C);
        drvEx(1'b1, OPCODE_BRANCH, BR_BLTU, 32'h0C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstbr_br_taken", 32'(bus.br_taken), 32'd1);
        chk("rstbr_mispredict", 32'(bus.mispredict), 32'd1);
        step();
        rst = 1'b0;
        drvEx(1'b0, 5'b00000, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstbr_branch_cnt", 32'(bus.branch_cnt), 32'd0);
        chk("rstbr_mis_cnt", 32'(bus.mispredict_cnt), 32'd0);
        chk("rstbr_pred_valid", 32'(bus.pred_valid), 32'd0);
        step();
        chk("rstbr_bht_init", 32'(bus.pred_taken), 32'd0);

        // Fill both statistics counters to all-ones, then one extra branch.
        lookup(1'b0, 32'h0);
        drvEx(1'b1, OPCODE_BRANCH, BR_BEQ, 32'h20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65535; i++) step();
        chk("fill_branch_cnt", 32'(bus.branch_cnt), 32'h0000_FFFF);
        chk("fill_mis_cnt", 32'(bus.mispredict_cnt), 32'h0000_FFFF);
        step();
        chk("sat_branch_cnt", 32'(bus.branch_cnt), 32'h0000_FFFF);
        chk("sat_mis_cnt", 32'(bus.mispredict_cnt), 32'h0000_FFFF);
        drvEx(1'b0, 5'b00000, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule : tb_branch_predict_unit
`default_nettype wire

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter IDX_BITS, default 4; BHT holds 2^IDX_BITS entries.
REQ-002 SHALL have parameter PC_W, default 32; program-counter width.
REQ-003 SHALL have parameter CNT_INIT, default 2'b01; BHT counter reset value (weakly not-taken).
REQ-004 SHALL have parameter STAT_W, default 16; statistics counter width.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 f_valid  in  1  fetch-stage lookup request.
REQ-008 f_pc  in  PC_W  fetch PC.
REQ-009 pred_valid  out  1  registered; f_valid delayed one cycle.
REQ-010 pred_taken  out  1  registered; prediction for the previous cycle's f_pc.
REQ-011 ex_valid  in  1  execute-stage instruction valid.
REQ-012 ex_pc  in  PC_W  execute-stage PC.
REQ-013 opcode  in  5  instruction bits [6:2].
REQ-014 funct3  in  3  branch condition field.
REQ-015 cf, zf, vf, sf  in  1 each  ALU carry, zero, overflow, sign flags from the compare subtraction.
REQ-016 ex_pred_taken  in  1  prediction carried down the pipeline with the instruction.
REQ-017 br_taken  out  1  combinational resolved outcome.
REQ-018 mispredict  out  1  combinational; flush request.
REQ-019 branch_cnt, mispredict_cnt  out  STAT_W each  registered statistics.

Function
REQ-020 Index SHALL be pc[IDX_BITS+1:2] for both lookup and update.
REQ-021 br_taken SHALL be 0 when ex_valid=0.
REQ-022 For Branch opcode (11000), br_taken SHALL be: BEQ zf; BNE ~zf; BLT sf!=vf; BGE sf==vf; BLTU ~cf; BGEU cf.
REQ-023 Undefined funct3 values (010, 011) SHALL give br_taken=0 and SHALL NOT update the BHT or the statistics.
REQ-024 For JAL (11011) and JALR (11001), br_taken SHALL be 1, mispredict 0, and the BHT and statistics SHALL be unchanged.
REQ-025 Every other opcode SHALL give br_taken=0 with no side effects.
REQ-026 All outputs SHALL be fully assigned in every path; no latches.
REQ-027 On a valid defined branch, mispredict SHALL be br_taken XOR ex_pred_taken.
REQ-028 On a valid defined branch, the indexed counter SHALL increment saturating at 11 if taken, or decrement saturating at 00 if not taken, at the next edge.
REQ-029 Lookup: when f_valid=1, pred_taken SHALL be counter[1] of the indexed entry at the next edge (1-cycle latency); when f_valid=0, pred_taken SHALL be 0.
REQ-030 On a same-cycle lookup and update to the same index, pred_taken SHALL use the post-update counter value (write bypass).
REQ-031 Each valid defined branch SHALL increment branch_cnt by 1, saturating at all-ones.
REQ-032 Each mispredict SHALL increment mispredict_cnt by 1, saturating at all-ones.

Reset
REQ-033 While rst=1, on each edge: all BHT entries SHALL load CNT_INIT, pred_valid and pred_taken SHALL be 0, and both statistics counters SHALL be 0.
REQ-034 rst SHALL take priority over a simultaneous update or lookup; no update pending at reset survives it.
REQ-035 br_taken and mispredict SHALL remain combinational functions of inputs during reset.

Structure
REQ-036 Opcode constants (including the new OPCODE_JALR) and BR_ funct3 constants SHALL live in the shared defines file.
REQ-037 Counter states SNT=00, WNT=01, WT=10, ST=11 SHALL also live in the shared defines file.
REQ-038 One sub-module, bht_table, SHALL hold the counter array with its saturating update and bypass read; the top level holds resolution and statistics.

Verification
REQ-039 Reset, then f_pc=0x40 with f_valid=1 -> one cycle later pred_valid=1, pred_taken=0 (entry is WNT).
REQ-040 At ex_pc=0x40, four BEQ with zf=1 and ex_pred_taken=0 -> entry moves 01→10→11→11; mispredict=1 on all four; branch_cnt=4, mispredict_cnt=4.
REQ-041 BLT with sf=1, vf=0 -> br_taken=1; BGEU with cf=0 -> br_taken=0; funct3=010 -> br_taken=0 and counters unchanged.
REQ-042 JAL and JALR with ex_valid=1 -> br_taken=1, mispredict=0, BHT and statistics unchanged.
REQ-043 Same cycle: update of index 3 taken (WT→ST) and lookup of f_pc=0x0C -> pred_taken=1 next cycle.
REQ-044 rst asserted in the same cycle as a valid taken branch -> entry reads CNT_INIT afterwards and statistics are 0; preset branch_cnt=0xFFFF plus one more branch -> remains 0xFFFF.
